compare_sort_ctrl: RTL
======================

Name: compare_sort_ctrl

Overview:
Sequencing controller that collects a block of DEPTH unsigned words and sorts them in ascending order. It uses a single compare-and-swap unit, one comparison per clock, with bubble-sort passes and early exit. The sorted block is then streamed out. It sits between a valid/ready producer and consumer, so one comparator can serve a whole buffer instead of a comparator array.

Parameters:
WIH, 3, data word width in bits (unsigned compare)
DEPTH, 4, words per block; legal range 2..16

Ports:
clk  input  1  system clock, all state updates on posedge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a word on in_data
in_data  input  WIH  input word
in_ready  output  1  controller accepts in_data this cycle
out_valid  output  1  out_data holds a sorted word
out_data  output  WIH  sorted word, smallest first
out_ready  input  1  consumer accepts out_data this cycle
busy  output  1  high in SORT or DRAIN
swap_cnt  output  8  swaps performed in the current or last block, saturates at 255

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=LOAD; buffer, all indices and pass/flag registers cleared.
  - Outputs: in_ready=1, out_valid=0, out_data=0, busy=0, swap_cnt=0.
- Storage: buf[0..DEPTH-1] of WIH bits each. Write pointer, compare index and read pointer are each clog2(DEPTH) bits wide.
- LOAD:
  - in_ready=1.
  - A beat is accepted when in_valid&&in_ready. The word goes to buf[wr_ptr] and wr_ptr increments.
  - swap_cnt clears to 0 on the first beat of a block.
  - On the DEPTH-th beat: next state SORT, wr_ptr=0, idx=0, pass=0, swapped=0.
- SORT, one compare per cycle:
  - in_ready=0, busy=1.
  - Compare buf[idx] > buf[idx+1] (unsigned, strict). If true, swap the two words, set swapped=1 and increment swap_cnt (saturating). Equal words are never swapped, so the sort is stable.
  - If idx<DEPTH-2: idx increments.
  - If idx==DEPTH-2 (end of pass): pass increments and idx=0.
    - If swapped==0 (including a swap in this final cycle) or pass+1==DEPTH-1: next state DRAIN.
    - Otherwise: swapped clears and another pass runs.
  - A pass takes exactly DEPTH-1 cycles. Sort latency is between DEPTH-1 and (DEPTH-1)^2 cycles.
- DRAIN:
  - out_valid=1 and out_data=buf[rd_ptr], driven combinationally from the registered rd_ptr.
  - On out_valid&&out_ready, rd_ptr increments.
  - On the DEPTH-th handshake: next state LOAD, rd_ptr=0, busy=0, out_valid=0.
  - With out_ready low, out_data and out_valid hold stable.
  - in_ready=0 throughout DRAIN; input is not pre-loaded.
- Boundary conditions:
  - in_valid while not in LOAD is ignored; no data loss, the producer holds.
  - swap_cnt stays valid after DRAIN until the first beat of the next block.
  - Reset asserted mid-SORT or mid-DRAIN discards the block. The first cycle after rst_n deasserts is LOAD with in_ready=1.
- No combinational path from in_valid to in_ready. out_valid depends on state only.

Test Plan:
- WIH=3, DEPTH=4: load 5,3,1,0, out_ready=1.
  - SORT lasts exactly 9 cycles (3 full passes).
  - Output stream is 0,1,3,5 on 4 consecutive cycles; swap_cnt=6.
- Load 0,1,2,3.
  - SORT lasts exactly 3 cycles (1 pass, no swaps) and swap_cnt=0.
  - Output is 0,1,2,3.
- Load 4,4,2,4.
  - Output is 2,4,4,4; swap_cnt=2.
  - No swap occurs on an equal pair.
- Load 6,2,7,1 with out_ready toggling 1,0,0,1,...
  - Output is 1,2,6,7.
  - out_data stays stable while out_ready=0; exactly 4 handshakes, then in_ready=1.
- Hold in_valid=1 with data 7 throughout SORT and DRAIN.
  - in_ready=0 until DRAIN completes.
  - The next block's first accepted word is the one presented on the first cycle of LOAD.
- Pull rst_n low for 1 cycle mid-SORT of 3,2,1,0.
  - out_valid=0, swap_cnt=0 and in_ready=1 immediately.
  - A fresh load of 1,0,3,2 outputs 0,1,2,3 with swap_cnt=2.

Source files
------------

// File: rtl/compare_sort_ctrl.sv
// Block sorter: collects DEPTH words, bubble-sorts them with one compare-and-swap
// per clock (early exit on a clean pass), then streams them out smallest first.
module compare_sort_ctrl #(
  parameter int unsigned WIH   = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [WIH-1:0] in_data,
  output logic           in_ready,
  output logic           out_valid,
  output logic [WIH-1:0] out_data,
  input  logic           out_ready,
  output logic           busy,
  output logic [7:0]     swap_cnt
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_SORT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [PW-1:0] LAST_IDX  = PW'(DEPTH - 2);
  localparam logic [PW-1:0] LAST_PASS = PW'(DEPTH - 2);

  logic [1:0]     state_q, state_d;
  logic [WIH-1:0] mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr, idx, pass;
  logic           swapped;
  logic [7:0]     swap_cnt_q;

  logic [PW-1:0]  idx_nx_c;
  logic [WIH-1:0] lo_word_c, hi_word_c;
  logic           gt_c, end_pass_c, swapped_nx_c, load_fire_c, drain_fire_c;

  // Compare-and-swap operands and handshake qualifiers
  always_comb begin
    idx_nx_c     = idx + PW'(1);
    lo_word_c    = mem[idx];
    hi_word_c    = mem[idx_nx_c];
    gt_c         = (state_q == S_SORT) && (lo_word_c > hi_word_c);
    end_pass_c   = (idx == LAST_IDX);
    swapped_nx_c = swapped | gt_c;
    load_fire_c  = (state_q == S_LOAD) && in_valid;
    drain_fire_c = (state_q == S_DRAIN) && out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (load_fire_c && (wr_ptr == LAST_PTR)) state_d = S_SORT;
      S_SORT:  if (end_pass_c && (!swapped_nx_c || (pass == LAST_PASS))) state_d = S_DRAIN;
      S_DRAIN: if (drain_fire_c && (rd_ptr == LAST_PTR)) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  // Buffer, pointers and pass bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      idx        <= '0;
      pass       <= '0;
      swapped    <= 1'b0;
      swap_cnt_q <= '0;
    end else begin
      case (state_q)
        S_LOAD: if (load_fire_c) begin
          mem[wr_ptr] <= in_data;
          if (wr_ptr == '0) swap_cnt_q <= '0;
          if (wr_ptr == LAST_PTR) begin
            wr_ptr  <= '0;
            idx     <= '0;
            pass    <= '0;
            swapped <= 1'b0;
          end else begin
            wr_ptr <= wr_ptr + PW'(1);
          end
        end
        S_SORT: begin
          if (gt_c) begin
            mem[idx]      <= hi_word_c;
            mem[idx_nx_c] <= lo_word_c;
            if (swap_cnt_q != 8'hFF) swap_cnt_q <= swap_cnt_q + 8'd1;
          end
          if (end_pass_c) begin
            idx     <= '0;
            pass    <= pass + PW'(1);
            swapped <= 1'b0;
          end else begin
            idx     <= idx_nx_c;
            swapped <= swapped_nx_c;
          end
        end
        S_DRAIN: if (drain_fire_c) begin
          rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
        end
        default: ;
      endcase
    end
  end

  // Status outputs decode straight from the state register
  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_DRAIN);
  assign busy      = (state_q != S_LOAD);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign swap_cnt  = swap_cnt_q;

endmodule
